// File: rtl/fifo_tx_pkg.sv
// Shared types and helpers for the FIFO-draining UART transmitter.
package fifo_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;

  // Cycles from TX falling to the end of the TX_DONE cycle.
  function automatic int unsigned frame_len(input int unsigned dw, input int unsigned cpb,
                                            input int unsigned par, input int unsigned stop);
    return cpb * (1 + dw + par + stop);
  endfunction

endpackage

// File: rtl/fifo_tx_bit_timer.sv
// Free-running bit-period counter; tick marks the last cycle of each bit period.
module fifo_tx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains words from the FIFO read port and sends each one as a serial frame:
// start bit, data LSB first, optional even parity, one or two stop bits.
module fifo_uart_tx
  import fifo_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENABLE,
  input  logic                  REMPTY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  output logic                  R_INC,
  output logic                  TX,
  output logic                  BUSY,
  output logic                  TX_DONE
);

  localparam int unsigned IW = $clog2(DATA_WIDTH + 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

  tx_state_t             state, state_nx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bit;
  logic [IW-1:0]         bit_idx;
  logic                  stop_idx;
  logic                  tick;
  logic                  timer_clear;
  logic                  last_stop;

  // The timer runs only while a frame is on the line, so START always sees a full bit.
  always_comb begin
    timer_clear = (state == IDLE) || (state == POP) || (state == LOAD);
    last_stop   = (STOP_BITS < 2) || stop_idx;
  end

  fifo_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .CLK  (CLK),
    .RST  (RST),
    .clear(timer_clear),
    .tick (tick)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      shreg    <= '0;
      par_bit  <= 1'b0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        LOAD: begin
          shreg    <= RDATA;
          par_bit  <= ^RDATA;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
        end
        DATA: begin
          if (tick) begin
            shreg   <= shreg >> 1;
            bit_idx <= (bit_idx == LAST_BIT) ? '0 : bit_idx + IW'(1);
          end
        end
        STOP: begin
          if (tick) begin
            stop_idx <= last_stop ? 1'b0 : 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    R_INC    = 1'b0;
    TX       = TX_IDLE_LEVEL;
    BUSY     = (state != IDLE);
    TX_DONE  = 1'b0;
    case (state)
      IDLE: begin
        if (ENABLE && !REMPTY) begin
          state_nx = POP;
        end
      end
      POP: begin
        R_INC    = 1'b1;
        state_nx = LOAD;
      end
      LOAD: begin
        state_nx = START;
      end
      START: begin
        TX = 1'b0;
        if (tick) begin
          state_nx = DATA;
        end
      end
      DATA: begin
        TX = shreg[0];
        if (tick && (bit_idx == LAST_BIT)) begin
          state_nx = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        TX = par_bit;
        if (tick) begin
          state_nx = STOP;
        end
      end
      STOP: begin
        if (tick && last_stop) begin
          TX_DONE  = 1'b1;
          state_nx = (ENABLE && !REMPTY) ? POP : IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (no parity / even parity) fed by queue-based FIFO models,
// each frame compared cycle by cycle against a line-level reference of the serial format.
module tb_fifo_uart_tx;
  import fifo_tx_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int unsigned CPB = 4;

  typedef struct {
    int         sel;
    logic [7:0] word;
    int         exp_len;
  } vec_t;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       enable = 1'b1;
  logic [1:0] rempty = 2'b11;
  logic [DW-1:0] rdata0 = '0;
  logic [DW-1:0] rdata1 = '0;
  logic [1:0] tx;
  logic [1:0] r_inc;
  logic [1:0] busy;
  logic [1:0] tx_done;
  logic [1:0] prev_rinc = 2'b00;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  int n_vec    = 0;
  int n_fail   = 0;
  int rinc_cnt[2] = '{0, 0};

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)
  ) dut (
    .CLK(clk), .RST(rst), .ENABLE(enable), .REMPTY(rempty[0]), .RDATA(rdata0),
    .R_INC(r_inc[0]), .TX(tx[0]), .BUSY(busy[0]), .TX_DONE(tx_done[0])
  );

  fifo_uart_tx #(
    .DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)
  ) dut_par (
    .CLK(clk), .RST(rst), .ENABLE(enable), .REMPTY(rempty[1]), .RDATA(rdata1),
    .R_INC(r_inc[1]), .TX(tx[1]), .BUSY(busy[1]), .TX_DONE(tx_done[1])
  );

  // FIFO models: registered read data, empty flag updated on the clock.
  always @(posedge clk) begin
    if (r_inc[0] && q0.size() != 0) rdata0 <= q0.pop_front();
    if (r_inc[1] && q1.size() != 0) rdata1 <= q1.pop_front();
    rempty <= {q1.size() == 0, q0.size() == 0};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (r_inc[i]) begin
        rinc_cnt[i]++;
        chk($sformatf("rinc_single_cycle[%0d]", i), prev_rinc[i], 1'b0);
        chk($sformatf("rinc_nonempty[%0d]", i), rempty[i], 1'b0);
      end
    end
    prev_rinc = r_inc;
  end

  // Expected line level k cycles after TX falls.
  function automatic logic ref_level(input logic [7:0] word, input int par, input int k);
    int p;
    p = k / CPB;
    if (p == 0) return 1'b0;
    if (p <= DW) return word[p-1];
    if (par != 0 && p == DW + 1) return ^word;
    return 1'b1;
  endfunction

  task automatic push(input int sel, input logic [7:0] w);
    if (sel == 0) q0.push_back(w);
    else q1.push_back(w);
  endtask

  task automatic wait_fall(input int sel, output int wait_cyc, output bit fell);
    wait_cyc = 0;
    while (tx[sel] !== 1'b0 && wait_cyc < 300) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk($sformatf("tx_fall[%0d]", sel), tx[sel], 1'b0);
    fell = (tx[sel] === 1'b0);
  endtask

  task automatic check_frame(input int sel, input logic [7:0] word, input int len,
                             input int drop_at, output int wait_cyc);
    logic [7:0] got;
    bit fell;
    got = '0;
    wait_fall(sel, wait_cyc, fell);
    if (!fell) return;
    for (int k = 0; k < len; k++) begin
      if (k > 0) @(negedge clk);
      if (k == drop_at) enable = 1'b0;
      chk($sformatf("tx_level[%0d] w=%0h k=%0d", sel, word, k), tx[sel], ref_level(word, sel, k));
      chk($sformatf("tx_done[%0d] w=%0h k=%0d", sel, word, k), tx_done[sel], (k == len - 1));
      if ((k % CPB) == CPB / 2 && k / CPB >= 1 && k / CPB <= DW) got[k/CPB-1] = tx[sel];
    end
    chk($sformatf("decoded_word[%0d]", sel), got, word);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   tbl[4];
    int     w;
    int     c;
    longint t0;
    longint t1;
    logic [7:0] rw;
    int     sel;

    tbl = '{'{1, 8'h07, 44}, '{1, 8'h03, 44}, '{0, 8'h5A, 40}, '{1, 8'hFF, 44}};

    // Reset held with data waiting; pop comes in the 2nd cycle after release.
    q0.push_back(8'hA5);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", {tx[0], r_inc[0], busy[0], tx_done[0]}, 4'b1000);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("first_rinc_2nd_cycle", r_inc[0], 1'b1);
    check_frame(0, 8'hA5, 40, -1, w);
    chk("pop_to_start_latency", w, 2);
    @(negedge clk);
    chk("idle_after_single", busy[0], 1'b0);

    for (int i = 0; i < 4; i++) begin
      push(tbl[i].sel, tbl[i].word);
      check_frame(tbl[i].sel, tbl[i].word, tbl[i].exp_len, -1, w);
      @(negedge clk);
      chk($sformatf("idle_after_vec%0d", i), busy[tbl[i].sel], 1'b0);
    end

    // Back-to-back frames.
    c = rinc_cnt[0];
    push(0, 8'h00); push(0, 8'hFF); push(0, 8'h3C);
    check_frame(0, 8'h00, 40, -1, w);
    t0 = $time;
    check_frame(0, 8'hFF, 40, -1, w);
    t1 = $time;
    chk("b2b_gap_1", w, 3);
    chk("b2b_done_spacing_1", 32'((t1 - t0) / 10), 42);
    check_frame(0, 8'h3C, 40, -1, w);
    t0 = $time;
    chk("b2b_gap_2", w, 3);
    chk("b2b_done_spacing_2", 32'((t0 - t1) / 10), 42);
    @(negedge clk);
    chk("b2b_pop_count", rinc_cnt[0] - c, 3);
    chk("b2b_idle", busy[0], 1'b0);

    // Empty FIFO never pops; ENABLE dropped mid-frame stops further pops.
    c = rinc_cnt[0] + rinc_cnt[1];
    repeat (100) @(negedge clk);
    chk("no_pop_when_empty", rinc_cnt[0] + rinc_cnt[1] - c, 0);
    c = rinc_cnt[0];
    push(0, 8'h81); push(0, 8'h42);
    check_frame(0, 8'h81, 40, 16, w);
    repeat (4) @(negedge clk);
    chk("disabled_idle", busy[0], 1'b0);
    chk("disabled_pop_count", rinc_cnt[0] - c, 1);
    chk("disabled_word_kept", q0.size(), 1);
    enable = 1'b1;
    check_frame(0, 8'h42, 40, -1, w);
    @(negedge clk);
    chk("reenabled_idle", busy[0], 1'b0);

    // Reset at the 3rd data bit; popped word is lost, next word sent cleanly.
    push(0, 8'hA5);
    begin
      bit fell;
      wait_fall(0, w, fell);
    end
    repeat (2 * CPB + CPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", tx[0], 1'b1);
    chk("rst_mid_busy", busy[0], 1'b0);
    chk("rst_mid_done", tx_done[0], 1'b0);
    c = rinc_cnt[0];
    rst = 1'b0;
    push(0, 8'hA5);
    check_frame(0, 8'hA5, 40, -1, w);
    @(negedge clk);
    chk("rst_recover_pops", rinc_cnt[0] - c, 1);

    // Random words on both instances, then a random burst on the parity instance.
    for (int i = 0; i < 8; i++) begin
      sel = int'($urandom_range(0, 1));
      rw  = 8'($urandom);
      push(sel, rw);
      check_frame(sel, rw, int'(frame_len(DW, CPB, sel, 1)), -1, w);
      @(negedge clk);
      chk("rand_idle", busy[sel], 1'b0);
    end
    begin
      logic [7:0] burst[3];
      for (int i = 0; i < 3; i++) begin
        burst[i] = 8'($urandom);
        push(1, burst[i]);
      end
      for (int i = 0; i < 3; i++) begin
        check_frame(1, burst[i], int'(frame_len(DW, CPB, 1, 1)), -1, w);
        if (i > 0) chk("rand_burst_gap", w, 3);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer for the FIFO. Drains words through the FIFO read port (R_INC/REMPTY/RDATA) and transmits each word as an asynchronous serial frame on TX.
- Runs entirely in the FIFO read clock domain, which is its single clock.
- Pops a word only when enabled and the FIFO is not empty, then serializes it LSB first with start, optional parity and stop bits.

Parameters:
- DATA_WIDTH, 8: width of a FIFO word and of the serial payload.
- CLKS_PER_BIT, 16: CLK cycles per serial bit. Legal range is 2 or more.
- PARITY_EN, 0: 1 inserts an even-parity bit after the data bits.
- STOP_BITS, 1: number of stop bits. Legal values are 1 or 2.

Ports:
- CLK, in, 1: clock (FIFO read clock).
- RST, in, 1: reset, synchronous, active-high.
- ENABLE, in, 1: 1 permits popping new words.
- REMPTY, in, 1: FIFO empty flag; 1 = empty.
- RDATA, in, DATA_WIDTH: FIFO read data. Registered; valid the cycle after an R_INC cycle.
- R_INC, out, 1: FIFO pop strobe. Exactly one cycle high per word.
- TX, out, 1: serial line. Idles high.
- BUSY, out, 1: 1 whenever state is not IDLE.
- TX_DONE, out, 1: one-cycle pulse on the last cycle of each frame's stop period.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: TX=1, R_INC=0, BUSY=0, TX_DONE=0, state=IDLE, bit timer=0, bit index=0.
- All outputs are registered or a pure decode of registered state. No input-to-output combinational path.
- States: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- IDLE: if ENABLE=1 and REMPTY=0 at the edge, go to POP. Otherwise stay in IDLE.
- POP: R_INC=1 for this one cycle. Always go to LOAD next.
- LOAD: capture RDATA into the shift register at the end of the cycle. Compute parity as the XOR of the data bits. Go to START.
- START: TX=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: TX = shift register bit 0, LSB first. Each bit is held CLKS_PER_BIT cycles, then the register shifts.
  - After DATA_WIDTH bits, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: TX = even-parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: TX=1 for STOP_BITS*CLKS_PER_BIT cycles. TX_DONE=1 on the final cycle.
  - On exit: if ENABLE=1 and REMPTY=0, go to POP (back-to-back frames). Otherwise go to IDLE.
- TX is 1 in IDLE, POP and LOAD.
- Latency: from the IDLE decision edge, R_INC is high in the next cycle and TX falls 2 edges later.
- Frame length: CLKS_PER_BIT*(1+DATA_WIDTH+PARITY_EN+STOP_BITS) cycles from TX falling to the end of the TX_DONE cycle.
- Inter-frame gap for back-to-back frames: the stop period plus 2 extra high cycles (POP and LOAD).
- Bit timer: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). Terminal count advances the bit or state.
  - Bit index width is $clog2(DATA_WIDTH+1).
- Empty FIFO: R_INC is never asserted while REMPTY=1. REMPTY is sampled only in IDLE and on STOP exit.
- ENABLE falling mid-frame: the current frame completes unchanged, with no further pop. BUSY drops after STOP.
- REMPTY changes mid-frame: ignored.
- RST mid-operation: the next edge forces reset values and TX returns high at once.
  - A word already popped but not fully sent is lost. This is accepted behaviour.
- R_INC is never asserted for two consecutive cycles.

Decomposition:
- Package fifo_tx_pkg holds:
  - enum tx_state_t (IDLE, POP, LOAD, START, DATA, PARITY, STOP);
  - constant TX_IDLE_LEVEL=1'b1;
  - function frame_len(dw, cpb, par, stop).
- One sub-module: fifo_tx_bit_timer (CLK, RST, clear, tick). It is a parameterized CLKS_PER_BIT counter that emits a terminal-count tick.

Test Plan (DATA_WIDTH=8, CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1 unless stated):
- Reset: hold RST=1 for 3 cycles with REMPTY=0, ENABLE=1 -> TX=1, R_INC=0, BUSY=0, TX_DONE=0 throughout. First R_INC occurs in the 2nd cycle after RST falls.
- Single word: FIFO holds 0xA5 -> one R_INC pulse. TX = start 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then stop 1 for 4 cycles. TX_DONE pulses at cycle 40 after TX falls. BUSY is 0 afterwards.
- Back-to-back: FIFO holds 0x00, 0xFF, 0x3C -> exactly 3 R_INC pulses. Each gap is 6 high cycles (4 stop + POP + LOAD). Three TX_DONE pulses, 42 cycles apart.
- Parity: PARITY_EN=1, word 0x07 -> parity bit 1 sent after bit 7. Frame is 44 cycles. Word 0x03 gives parity bit 0.
- Enable/empty gating: REMPTY=1, ENABLE=1 for 100 cycles gives no R_INC. Then fill 2 words and drop ENABLE during the first frame's DATA state -> frame 1 completes, no second R_INC, BUSY=0.
- Reset mid-frame: assert RST at the 3rd data bit of 0xA5 -> next cycle TX=1, BUSY=0. After RST falls with REMPTY=0, a fresh pop and full frame occur.
